// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared constants and types for the immediate generator pipeline
package imm_pkg;

    localparam logic [2:0] IMM_SEL_NONE = 3'd0;
    localparam logic [2:0] IMM_SEL_I    = 3'd1;
    localparam logic [2:0] IMM_SEL_S    = 3'd2;
    localparam logic [2:0] IMM_SEL_B    = 3'd3;
    localparam logic [2:0] IMM_SEL_U    = 3'd4;
    localparam logic [2:0] IMM_SEL_J    = 3'd5;
    localparam logic [2:0] IMM_SEL_Z    = 3'd6;
    localparam logic [2:0] IMM_SEL_RSV  = 3'd7;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    function automatic int payload_w(input int xlen, input int tagw);
        return xlen + 1 + tagw;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - valid/ready stream bundle used between pipeline stages
interface imm_gen_pipe_if #(
    parameter int DW = 8
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/imm_skid_buf.sv
// rtl/imm_skid_buf.sv - 2-entry valid/ready skid buffer with registered ready
module imm_skid_buf
    import imm_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    imm_gen_pipe_if.slave  s,
    imm_gen_pipe_if.master m
);

    buf_state_e    state, state_nx;
    logic [DW-1:0] main_q, skid_q;
    logic          in_ready_q;
    logic          out_valid;
    logic          in_fire, out_fire;
    logic          load_main, load_skid, pop_skid;

    assign out_valid = (state != BUF_EMPTY);
    assign in_fire   = s.tvalid & in_ready_q;
    assign out_fire  = out_valid & m.tready;

    assign s.tready  = in_ready_q;
    assign m.tvalid  = out_valid;
    assign m.tdata   = main_q;

    always_comb begin
        state_nx  = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (in_fire) begin
                    load_main = 1'b1;
                    state_nx  = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (in_fire && !out_fire) begin
                    load_skid = 1'b1;
                    state_nx  = BUF_FULL;
                end else if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (out_fire) begin
                    state_nx  = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (out_fire) begin
                    pop_skid = 1'b1;
                    state_nx = BUF_ONE;
                end
            end
            default: state_nx = BUF_EMPTY;
        endcase
    end

    // Ready is derived from the next state so it is a flop output, never a
    // combinational function of the downstream ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= BUF_EMPTY;
            in_ready_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state      <= state_nx;
            in_ready_q <= (state_nx != BUF_FULL);
            if (load_main) begin
                main_q <= s.tdata;
            end else if (pop_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= s.tdata;
            end
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered, flow-controlled RISC-V immediate generator
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            CLK_i,
    input  logic            RST_N_i,
    input  logic [31:0]     INST_i,
    input  logic [2:0]      IMM_sel_i,
    input  logic [TAGW-1:0] TAG_i,
    input  logic            IN_valid_i,
    output logic            IN_ready_o,
    output logic [XLEN-1:0] IMM_V_o,
    output logic [TAGW-1:0] TAG_o,
    output logic            ILL_o,
    output logic            OUT_valid_o,
    input  logic            OUT_ready_i
);

    localparam int PW = payload_w(XLEN, TAGW);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    logic [31:0]     imm32;
    logic            sext;
    logic            ill;
    logic [XLEN-1:0] imm;
    logic            unused_opcode;

    assign unused_opcode = ^INST_i[6:0];

    always_comb begin
        imm32 = '0;
        sext  = 1'b1;
        ill   = 1'b0;
        case (IMM_sel_i)
            IMM_SEL_I: imm32 = {{20{INST_i[31]}}, INST_i[31:20]};
            IMM_SEL_S: imm32 = {{20{INST_i[31]}}, INST_i[31:25], INST_i[11:7]};
            IMM_SEL_B: imm32 = {{19{INST_i[31]}}, INST_i[31], INST_i[7],
                                INST_i[30:25], INST_i[11:8], 1'b0};
            IMM_SEL_U: imm32 = {INST_i[31:12], 12'b0};
            IMM_SEL_J: imm32 = {{11{INST_i[31]}}, INST_i[31], INST_i[19:12],
                                INST_i[20], INST_i[30:21], 1'b0};
            IMM_SEL_Z: begin
                imm32 = {27'b0, INST_i[19:15]};
                sext  = 1'b0;
            end
            default: begin
                // NONE and RSV both flag illegal and force an all-ones immediate
                imm32 = '1;
                ill   = 1'b1;
            end
        endcase
    end

    assign imm = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);

    imm_gen_pipe_if #(.DW(PW)) in_bus ();
    imm_gen_pipe_if #(.DW(PW)) out_bus ();

    assign in_bus.tdata   = {imm, ill, TAG_i};
    assign in_bus.tvalid  = IN_valid_i;
    assign IN_ready_o     = in_bus.tready;

    assign out_bus.tready = OUT_ready_i;
    assign OUT_valid_o    = out_bus.tvalid;
    assign {IMM_V_o, ILL_o, TAG_o} = out_bus.tdata;

    imm_skid_buf #(.DW(PW)) u_buf (
        .clk   (CLK_i),
        .rst_n (RST_N_i),
        .s     (in_bus.slave),
        .m     (out_bus.master)
    );

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic out_ready;

    imm_gen_pipe_if #(.DW(40)) src ();

    logic        in_ready32, in_ready64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [4:0]  tag32, tag64;
    logic        ill32, ill64;
    logic        ov32, ov64;

    int n_vec = 0;
    int n_err = 0;

    imm_gen_pipe #(.XLEN(32), .TAGW(5)) dut32 (
        .CLK_i       (clk),
        .RST_N_i     (rst_n),
        .INST_i      (src.tdata[39:8]),
        .IMM_sel_i   (src.tdata[7:5]),
        .TAG_i       (src.tdata[4:0]),
        .IN_valid_i  (src.tvalid),
        .IN_ready_o  (in_ready32),
        .IMM_V_o     (imm32),
        .TAG_o       (tag32),
        .ILL_o       (ill32),
        .OUT_valid_o (ov32),
        .OUT_ready_i (out_ready)
    );

    imm_gen_pipe #(.XLEN(64), .TAGW(5)) dut64 (
        .CLK_i       (clk),
        .RST_N_i     (rst_n),
        .INST_i      (src.tdata[39:8]),
        .IMM_sel_i   (src.tdata[7:5]),
        .TAG_i       (src.tdata[4:0]),
        .IN_valid_i  (src.tvalid),
        .IN_ready_o  (in_ready64),
        .IMM_V_o     (imm64),
        .TAG_o       (tag64),
        .ILL_o       (ill64),
        .OUT_valid_o (ov64),
        .OUT_ready_i (out_ready)
    );

    assign src.tready = in_ready32;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [2:0] sel,
                         input logic [4:0] tag, input logic v);
        src.tdata  = {inst, sel, tag};
        src.tvalid = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        drive(32'h0, 3'd0, 5'd0, 1'b0);
        repeat (2) cyc();
        n_vec++; if (in_ready32 !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready32); end
        n_vec++; if (ov32 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", ov32); end
        n_vec++; if (imm32 !== 32'h0) begin n_err++; $display("FAIL reset_imm32 got=%h exp=0", imm32); end
        n_vec++; if (imm64 !== 64'h0) begin n_err++; $display("FAIL reset_imm64 got=%h exp=0", imm64); end
        n_vec++; if (tag32 !== 5'h0 || ill32 !== 1'b0) begin n_err++; $display("FAIL reset_tag_ill got=%h/%b exp=0/0", tag32, ill32); end
        rst_n = 1'b1;
        cyc();
        n_vec++; if (in_ready32 !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready32); end
        n_vec++; if (ov32 !== 1'b0) begin n_err++; $display("FAIL post_reset_out_valid got=%b exp=0", ov32); end
    endtask

    task automatic test_i_type();
        out_ready = 1'b1;
        drive(32'hFFF00093, 3'd1, 5'd3, 1'b1);
        cyc();
        drive(32'h0, 3'd0, 5'd0, 1'b0);
        n_vec++; if (ov32 !== 1'b1) begin n_err++; $display("FAIL i_valid got=%b exp=1", ov32); end
        n_vec++; if (imm32 !== 32'hFFFFFFFF) begin n_err++; $display("FAIL i_imm32 got=%h exp=ffffffff", imm32); end
        n_vec++; if (imm64 !== 64'hFFFFFFFF_FFFFFFFF) begin n_err++; $display("FAIL i_imm64 got=%h exp=ffffffffffffffff", imm64); end
        n_vec++; if (ill32 !== 1'b0 || tag32 !== 5'd3) begin n_err++; $display("FAIL i_ill_tag got=%b/%h exp=0/3", ill32, tag32); end
        cyc();
        n_vec++; if (ov32 !== 1'b0) begin n_err++; $display("FAIL i_drained got=%b exp=0", ov32); end
    endtask

    task automatic test_u_z_xlen64();
        out_ready = 1'b1;
        drive(32'h800002B7, 3'd4, 5'd4, 1'b1);
        cyc();
        n_vec++; if (imm64 !== 64'hFFFFFFFF_80000000) begin n_err++; $display("FAIL u_imm64 got=%h exp=ffffffff80000000", imm64); end
        n_vec++; if (imm32 !== 32'h80000000) begin n_err++; $display("FAIL u_imm32 got=%h exp=80000000", imm32); end
        drive(32'h0007D073, 3'd6, 5'd5, 1'b1);
        cyc();
        drive(32'h0, 3'd0, 5'd0, 1'b0);
        n_vec++; if (ov64 !== 1'b1 || tag64 !== 5'd5) begin n_err++; $display("FAIL z_valid_tag got=%b/%h exp=1/5", ov64, tag64); end
        n_vec++; if (imm64 !== 64'h0000000000000000F) begin n_err++; $display("FAIL z_imm64 got=%h exp=000000000000000f", imm64); end
        n_vec++; if (ill64 !== 1'b0) begin n_err++; $display("FAIL z_ill got=%b exp=0", ill64); end
        cyc();
    endtask

    task automatic test_fields();
        out_ready = 1'b1;
        drive(32'hFE000EE3, 3'd3, 5'd6, 1'b1);
        cyc();
        n_vec++; if (imm32 !== 32'hFFFFFFFC) begin n_err++; $display("FAIL b_imm32 got=%h exp=fffffffc", imm32); end
        n_vec++; if (imm64 !== 64'hFFFFFFFF_FFFFFFFC) begin n_err++; $display("FAIL b_imm64 got=%h exp=fffffffffffffffc", imm64); end
        drive(32'h0080006F, 3'd5, 5'd7, 1'b1);
        cyc();
        n_vec++; if (imm32 !== 32'h00000008 || tag32 !== 5'd7) begin n_err++; $display("FAIL j_imm32 got=%h/%h exp=00000008/07", imm32, tag32); end
        drive(32'hFE112E23, 3'd2, 5'd8, 1'b1);
        cyc();
        n_vec++; if (imm32 !== 32'hFFFFFFFC || tag32 !== 5'd8) begin n_err++; $display("FAIL s_imm32 got=%h/%h exp=fffffffc/08", imm32, tag32); end
        drive(32'h00500093, 3'd1, 5'd9, 1'b1);
        cyc();
        drive(32'h0, 3'd0, 5'd0, 1'b0);
        n_vec++; if (imm32 !== 32'h00000005 || ov32 !== 1'b1) begin n_err++; $display("FAIL i_pos_imm32 got=%h/%b exp=00000005/1", imm32, ov32); end
        n_vec++; if (imm64 !== 64'h5) begin n_err++; $display("FAIL i_pos_imm64 got=%h exp=5", imm64); end
        cyc();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(32'h12345678, 3'd7, 5'h15, 1'b1);
        cyc();
        n_vec++; if (ill32 !== 1'b1 || imm32 !== 32'hFFFFFFFF) begin n_err++; $display("FAIL rsv_ill_imm got=%b/%h exp=1/ffffffff", ill32, imm32); end
        n_vec++; if (tag32 !== 5'h15) begin n_err++; $display("FAIL rsv_tag got=%h exp=15", tag32); end
        n_vec++; if (ill64 !== 1'b1 || imm64 !== 64'hFFFFFFFF_FFFFFFFF) begin n_err++; $display("FAIL rsv_imm64 got=%b/%h exp=1/ffffffffffffffff", ill64, imm64); end
        drive(32'h00500093, 3'd0, 5'h0A, 1'b1);
        cyc();
        drive(32'h0, 3'd0, 5'd0, 1'b0);
        n_vec++; if (ill32 !== 1'b1 || imm32 !== 32'hFFFFFFFF || tag32 !== 5'h0A) begin n_err++; $display("FAIL none_ill_imm_tag got=%b/%h/%h exp=1/ffffffff/0a", ill32, imm32, tag32); end
        cyc();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(32'h00100093, 3'd1, 5'd1, 1'b1);
        cyc();
        n_vec++; if (ov32 !== 1'b1 || tag32 !== 5'd1 || in_ready32 !== 1'b1) begin n_err++; $display("FAIL bp_first got=%b/%h/%b exp=1/01/1", ov32, tag32, in_ready32); end
        drive(32'h00200093, 3'd1, 5'd2, 1'b1);
        cyc();
        n_vec++; if (in_ready32 !== 1'b0 || tag32 !== 5'd1) begin n_err++; $display("FAIL bp_full got=%b/%h exp=0/01", in_ready32, tag32); end
        drive(32'h00300093, 3'd1, 5'd3, 1'b1);
        cyc();
        n_vec++; if (in_ready32 !== 1'b0 || tag32 !== 5'd1 || imm32 !== 32'd1) begin n_err++; $display("FAIL bp_hold got=%b/%h/%h exp=0/01/00000001", in_ready32, tag32, imm32); end
        out_ready = 1'b1;
        cyc();
        n_vec++; if (ov32 !== 1'b1 || tag32 !== 5'd2 || imm32 !== 32'd2) begin n_err++; $display("FAIL bp_out2 got=%b/%h/%h exp=1/02/00000002", ov32, tag32, imm32); end
        n_vec++; if (in_ready32 !== 1'b1) begin n_err++; $display("FAIL bp_ready_back got=%b exp=1", in_ready32); end
        cyc();
        drive(32'h0, 3'd0, 5'd0, 1'b0);
        n_vec++; if (ov32 !== 1'b1 || tag32 !== 5'd3 || imm32 !== 32'd3) begin n_err++; $display("FAIL bp_out3 got=%b/%h/%h exp=1/03/00000003", ov32, tag32, imm32); end
        cyc();
        n_vec++; if (ov32 !== 1'b0) begin n_err++; $display("FAIL bp_no_dup got=%b exp=0", ov32); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        drive(32'h00700093, 3'd1, 5'd7, 1'b1);
        cyc();
        drive(32'h00800093, 3'd1, 5'd8, 1'b1);
        cyc();
        drive(32'h0, 3'd0, 5'd0, 1'b0);
        n_vec++; if (in_ready32 !== 1'b0 || ov32 !== 1'b1) begin n_err++; $display("FAIL mr_full got=%b/%b exp=0/1", in_ready32, ov32); end
        rst_n = 1'b0;
        cyc();
        n_vec++; if (ov32 !== 1'b0 || in_ready32 !== 1'b0) begin n_err++; $display("FAIL mr_in_reset got=%b/%b exp=0/0", ov32, in_ready32); end
        n_vec++; if (tag32 !== 5'd0 || imm32 !== 32'd0) begin n_err++; $display("FAIL mr_payload got=%h/%h exp=00/00000000", tag32, imm32); end
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        n_vec++; if (in_ready32 !== 1'b1 || ov32 !== 1'b0) begin n_err++; $display("FAIL mr_after got=%b/%b exp=1/0", in_ready32, ov32); end
        cyc();
        n_vec++; if (ov32 !== 1'b0 || ov64 !== 1'b0) begin n_err++; $display("FAIL mr_no_stale got=%b/%b exp=0/0", ov32, ov64); end
    endtask

    initial begin
        test_reset();
        test_i_type();
        test_u_z_xlen64();
        test_fields();
        test_illegal();
        test_backpressure();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
